// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, with an optional
// repetition count and idle gap between repetitions, to feed sequence detectors.
module seq_pattern_gen #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 4
) (
    input  logic               clk_pulse,
    input  logic               clear,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len_m1,
    input  logic [3:0]         repeat_m1,
    input  logic [3:0]         gap,
    output logic               out_bit,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic [1:0]         present_state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] SEND = 2'b01;
    localparam logic [1:0] GAP  = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    localparam logic [LEN_W-1:0] IDX_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] IDX_ZERO = LEN_W'(0);

    logic [1:0]         state_r,   state_s;
    logic [MAX_LEN-1:0] pat_r,     pat_s;
    logic [LEN_W-1:0]   len_r,     len_s;
    logic [LEN_W-1:0]   idx_r,     idx_s;
    logic [3:0]         rep_r,     rep_s;
    logic [3:0]         gap_len_r, gap_len_s;
    logic [3:0]         gap_cnt_r, gap_cnt_s;

    logic out_bit_r,   out_bit_s;
    logic out_valid_r, out_valid_s;
    logic busy_r,      busy_s;
    logic done_r,      done_s;

    // Next-state and counter update logic.
    always_comb begin
        state_s   = state_r;
        pat_s     = pat_r;
        len_s     = len_r;
        idx_s     = idx_r;
        rep_s     = rep_r;
        gap_len_s = gap_len_r;
        gap_cnt_s = gap_cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    pat_s     = pattern;
                    len_s     = len_m1;
                    idx_s     = len_m1;
                    rep_s     = repeat_m1;
                    gap_len_s = gap;
                    gap_cnt_s = 4'd0;
                    state_s   = SEND;
                end else begin
                    state_s   = IDLE;
                end
            end
            SEND: begin
                if (idx_r == IDX_ZERO) begin
                    if (rep_r == 4'd0) begin
                        state_s = DONE;
                    end else if (gap_len_r != 4'd0) begin
                        state_s   = GAP;
                        gap_cnt_s = gap_len_r - 4'd1;
                        rep_s     = rep_r - 4'd1;
                    end else begin
                        // Zero gap: reload immediately so repetitions abut with no bubble.
                        state_s = SEND;
                        idx_s   = len_r;
                        rep_s   = rep_r - 4'd1;
                    end
                end else begin
                    idx_s = idx_r - IDX_ONE;
                end
            end
            GAP: begin
                if (gap_cnt_r == 4'd0) begin
                    state_s = SEND;
                    idx_s   = len_r;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state so outputs stay registered.
    always_comb begin
        out_bit_s   = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_s)
            SEND: begin
                out_bit_s   = pat_s[idx_s];
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            GAP: begin
                busy_s = 1'b1;
            end
            DONE: begin
                done_s = 1'b1;
            end
            IDLE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, capture and output registers with synchronous clear.
    always_ff @(posedge clk_pulse) begin
        if (clear) begin
            state_r     <= IDLE;
            pat_r       <= '0;
            len_r       <= '0;
            idx_r       <= '0;
            rep_r       <= 4'd0;
            gap_len_r   <= 4'd0;
            gap_cnt_r   <= 4'd0;
            out_bit_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            pat_r       <= pat_s;
            len_r       <= len_s;
            idx_r       <= idx_s;
            rep_r       <= rep_s;
            gap_len_r   <= gap_len_s;
            gap_cnt_r   <= gap_cnt_s;
            out_bit_r   <= out_bit_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign out_bit       = out_bit_r;
    assign out_valid     = out_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign present_state = state_r;

endmodule
